// File: rtl/uart_word_serializer.sv
// Word FIFO plus LSB-first byte serializer feeding the UART transmitter.
// Optional frame marker: define SER_FRAME_MARKER_EN to emit MARK_BYTE after each word flagged in_last.
module uart_word_serializer #(
    parameter int         WORD_W    = 32,
    parameter int         DEPTH     = 16,
    parameter logic [7:0] MARK_BYTE = 8'h0A
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic [WORD_W-1:0]        in_data,
    input  logic                     in_last,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic [7:0]               out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     busy
);
    localparam int NB = WORD_W / 8;
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam int IW = (NB > 1) ? $clog2(NB) : 1;

`ifdef SER_FRAME_MARKER_EN
    typedef enum logic [1:0] {IDLE, SEND, MARK} state_t;
`else
    typedef enum logic [0:0] {IDLE, SEND} state_t;
`endif

    state_t              state_q, state_d;
    logic [WORD_W:0]     mem [DEPTH];
    logic [AW-1:0]       wrPtr_q, rdPtr_q;
    logic [LW-1:0]       level_q, level_d;
    logic [WORD_W-1:0]   word_q, word_d;
    logic                last_q, last_d;
    logic [IW-1:0]       idx_q, idx_d;
    logic [7:0]          outData_q, outData_d;
    logic                outValid_q, outValid_d;

    logic                push, pop, hs, lastByte, levelNz;
    logic                wordDone, markStart;
    logic [WORD_W:0]     head;

    assign head     = mem[rdPtr_q];
    assign levelNz  = (level_q != '0);
    assign in_ready = (level_q != LW'(DEPTH));
    assign push     = in_valid && in_ready;
    assign hs       = outValid_q && out_ready;
    assign lastByte = (idx_q == IW'(NB - 1));

    // word_q holds the bytes not yet presented, so the next byte is always word_q[7:0]
`ifdef SER_FRAME_MARKER_EN
    assign markStart = hs && (state_q == SEND) && lastByte && last_q;
    assign wordDone  = hs && (((state_q == SEND) && lastByte && !last_q) || (state_q == MARK));
`else
    logic unusedMark;
    assign unusedMark = ^{MARK_BYTE, last_q};
    assign markStart  = 1'b0;
    assign wordDone   = hs && (state_q == SEND) && lastByte;
`endif

    assign pop = ((state_q == IDLE) || wordDone) && levelNz;

    assign out_data  = outData_q;
    assign out_valid = outValid_q;
    assign level     = level_q;
    assign busy      = (state_q != IDLE) || levelNz;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q    <= IDLE;
            wrPtr_q    <= '0;
            rdPtr_q    <= '0;
            level_q    <= '0;
            word_q     <= '0;
            last_q     <= 1'b0;
            idx_q      <= '0;
            outData_q  <= '0;
            outValid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            level_q    <= level_d;
            word_q     <= word_d;
            last_q     <= last_d;
            idx_q      <= idx_d;
            outData_q  <= outData_d;
            outValid_q <= outValid_d;
            if (push) wrPtr_q <= wrPtr_q + AW'(1);
            if (pop)  rdPtr_q <= rdPtr_q + AW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wrPtr_q] <= {in_last, in_data};
    end

    always_comb begin
        level_d = level_q;
        if (push && !pop)      level_d = level_q + LW'(1);
        else if (pop && !push) level_d = level_q - LW'(1);
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (levelNz) state_d = SEND;
            default: begin
                if (wordDone) state_d = levelNz ? SEND : IDLE;
`ifdef SER_FRAME_MARKER_EN
                if (markStart) state_d = MARK;
`endif
            end
        endcase
    end

    always_comb begin
        word_d     = word_q;
        last_d     = last_q;
        idx_d      = idx_q;
        outData_d  = outData_q;
        outValid_d = outValid_q;
        if (pop) begin
            word_d     = head[WORD_W-1:0] >> 8;
            last_d     = head[WORD_W];
            idx_d      = '0;
            outData_d  = head[7:0];
            outValid_d = 1'b1;
        end else if (markStart) begin
            outData_d  = MARK_BYTE;
        end else if (wordDone) begin
            outValid_d = 1'b0;
        end else if ((state_q == SEND) && hs) begin
            idx_d      = idx_q + IW'(1);
            outData_d  = word_q[7:0];
            word_d     = word_q >> 8;
        end
    end

endmodule

// File: tb/tb_uart_word_serializer.sv
// Self-checking bench for uart_word_serializer: vector table, directed corner cases and
// randomized traffic checked against a byte-queue reference model.
module tb_uart_word_serializer;
    localparam int         WORD_W    = 32;
    localparam int         DEPTH     = 16;
    localparam int         NB        = WORD_W / 8;
    localparam int         LW        = $clog2(DEPTH) + 1;
    localparam logic [7:0] MARK_BYTE = 8'h0A;

    logic              clk = 1'b0;
    logic              rstn = 1'b0;
    logic [WORD_W-1:0] in_data = '0;
    logic              in_last = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [7:0]        out_data;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [LW-1:0]     level;
    logic              busy;

    uart_word_serializer #(.WORD_W(WORD_W), .DEPTH(DEPTH), .MARK_BYTE(MARK_BYTE)) dut (
        .clk(clk), .rstn(rstn),
        .in_data(in_data), .in_last(in_last), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .level(level), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] word;
        logic [31:0] expSeq;
    } vec_t;

    int          testsRun = 0;
    int          testsFailed = 0;
    int          byteCount = 0;
    logic [7:0]  modelQ[$];
    logic [7:0]  rxQ[$];
    logic        holdValid = 1'b0;
    logic [7:0]  holdData = '0;
    logic [7:0]  expByte;
    vec_t        vecs[5];
    int          accepted, waitN, base, run, firstIdx, lastIdx;
    logic        acc;
    logic [31:0] e;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        testsRun++;
        if (act !== exp) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic [WORD_W-1:0] d, input logic l, input logic r);
        in_valid  = v;
        in_data   = d;
        in_last   = l;
        out_ready = r;
    endtask

    task automatic cycle();
        @(posedge clk);
        #2;
    endtask

    // Reference model: every accepted word becomes its bytes LSB first (plus marker), in order
    always @(negedge clk) begin
        if (!rstn) begin
            modelQ.delete();
            holdValid = 1'b0;
        end else begin
            checkOutput("inReadyRule", 64'(in_ready), 64'(level != LW'(DEPTH)));
            if (holdValid) begin
                checkOutput("holdValid", 64'(out_valid), 64'(1));
                checkOutput("holdData", 64'(out_data), 64'(holdData));
            end
            if (out_valid && out_ready) begin
                checkOutput("modelNotEmpty", 64'(modelQ.size() != 0), 64'(1));
                if (modelQ.size() != 0) begin
                    expByte = modelQ.pop_front();
                    checkOutput("byteOrder", 64'(out_data), 64'(expByte));
                end
                rxQ.push_back(out_data);
                byteCount++;
            end
            if (in_valid && in_ready) begin
                for (int i = 0; i < NB; i++) modelQ.push_back(in_data[8*i +: 8]);
`ifdef SER_FRAME_MARKER_EN
                if (in_last) modelQ.push_back(MARK_BYTE);
`endif
            end
            holdValid = out_valid && !out_ready;
            holdData  = out_data;
        end
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vecs[0] = '{word: 32'hDDCCBBAA, expSeq: 32'hAABBCCDD};
        vecs[1] = '{word: 32'h01234567, expSeq: 32'h67452301};
        vecs[2] = '{word: 32'h00000000, expSeq: 32'h00000000};
        vecs[3] = '{word: 32'hFF00FF80, expSeq: 32'h80FF00FF};
        vecs[4] = '{word: 32'h80000001, expSeq: 32'h01000080};

        // Reset state
        applyStimulus(1'b0, '0, 1'b0, 1'b1);
        rstn = 1'b0;
        repeat (3) cycle();
        checkOutput("rstInReady", 64'(in_ready), 64'(1));
        checkOutput("rstOutValid", 64'(out_valid), 64'(0));
        checkOutput("rstOutData", 64'(out_data), 64'(0));
        checkOutput("rstLevel", 64'(level), 64'(0));
        checkOutput("rstBusy", 64'(busy), 64'(0));
        rstn = 1'b1;
        cycle();

        // Single word: latency and return to idle
        applyStimulus(1'b1, 32'hDDCCBBAA, 1'b0, 1'b1);
        cycle();
        applyStimulus(1'b0, '0, 1'b0, 1'b1);
        checkOutput("latencyEarly", 64'(out_valid), 64'(0));
        checkOutput("levelAfterPush", 64'(level), 64'(1));
        cycle();
        checkOutput("latencyValid", 64'(out_valid), 64'(1));
        checkOutput("firstByte", 64'(out_data), 64'(8'hAA));
        checkOutput("levelAfterPop", 64'(level), 64'(0));
        repeat (4) cycle();
        checkOutput("idleValid", 64'(out_valid), 64'(0));
        checkOutput("idleBusy", 64'(busy), 64'(0));

        // Vector table
        for (int v = 0; v < 5; v++) begin
            rxQ.delete();
            applyStimulus(1'b1, vecs[v].word, 1'b0, 1'b1);
            cycle();
            applyStimulus(1'b0, '0, 1'b0, 1'b1);
            waitN = 0;
            while (rxQ.size() < NB && waitN < 20) begin
                cycle();
                waitN++;
            end
            checkOutput("vecByteCount", 64'(rxQ.size()), 64'(NB));
            e = vecs[v].expSeq;
            for (int i = 0; i < NB && i < rxQ.size(); i++)
                checkOutput("vecByte", 64'(rxQ[i]), 64'(e[8*(NB-1-i) +: 8]));
            repeat (2) cycle();
        end

        // Fill with output stalled
        accepted = 0;
        for (int c = 0; c < 40 && in_ready; c++) begin
            applyStimulus(1'b1, WORD_W'($urandom), 1'b0, 1'b0);
            acc = in_ready;
            cycle();
            if (acc) accepted++;
        end
        checkOutput("fillAccepted", 64'(accepted), 64'(DEPTH + 1));
        checkOutput("fullLevel", 64'(level), 64'(DEPTH));
        checkOutput("fullInReady", 64'(in_ready), 64'(0));
        repeat (3) cycle();
        checkOutput("fullLevelHeld", 64'(level), 64'(DEPTH));
        checkOutput("fullOutValid", 64'(out_valid), 64'(1));
        base = byteCount;
        applyStimulus(1'b0, '0, 1'b0, 1'b1);
        waitN = 0;
        while (busy && waitN < 200) begin
            cycle();
            waitN++;
        end
        checkOutput("fillDrainBusy", 64'(busy), 64'(0));
        checkOutput("fillBytes", 64'(byteCount - base), 64'((DEPTH + 1) * NB));

        // Back-to-back words leave no gap in out_valid
        run = 0;
        firstIdx = -1;
        lastIdx = -1;
        for (int c = 0; c < 25; c++) begin
            if (c < 3) applyStimulus(1'b1, WORD_W'($urandom), 1'b0, 1'b1);
            else       applyStimulus(1'b0, '0, 1'b0, 1'b1);
            if (out_valid) begin
                run++;
                if (firstIdx < 0) firstIdx = c;
                lastIdx = c;
            end
            cycle();
        end
        checkOutput("b2bCount", 64'(run), 64'(3 * NB));
        checkOutput("b2bSpan", 64'(lastIdx - firstIdx + 1), 64'(3 * NB));

        // Frame marker
        rxQ.delete();
        base = byteCount;
        applyStimulus(1'b1, 32'h44332211, 1'b0, 1'b1);
        cycle();
        applyStimulus(1'b1, 32'h88776655, 1'b1, 1'b1);
        cycle();
        applyStimulus(1'b0, '0, 1'b0, 1'b1);
        repeat (20) cycle();
`ifdef SER_FRAME_MARKER_EN
        checkOutput("markBytes", 64'(byteCount - base), 64'(2 * NB + 1));
        if (rxQ.size() > 2 * NB) checkOutput("markByte", 64'(rxQ[2*NB]), 64'(8'h0A));
`else
        checkOutput("markBytes", 64'(byteCount - base), 64'(2 * NB));
`endif
        if (rxQ.size() >= 2 * NB) checkOutput("markLastData", 64'(rxQ[2*NB-1]), 64'(8'h88));

        // Reset mid-word with words queued
        for (int c = 0; c < 4; c++) begin
            applyStimulus(1'b1, WORD_W'($urandom), 1'b0, 1'b0);
            cycle();
        end
        applyStimulus(1'b0, '0, 1'b0, 1'b0);
        checkOutput("queuedLevel", 64'(level), 64'(3));
        base = byteCount;
        applyStimulus(1'b0, '0, 1'b0, 1'b1);
        waitN = 0;
        while (byteCount < base + 2 && waitN < 10) begin
            cycle();
            waitN++;
        end
        checkOutput("preResetBytes", 64'(byteCount - base), 64'(2));
        rstn = 1'b0;
        cycle();
        checkOutput("midRstValid", 64'(out_valid), 64'(0));
        checkOutput("midRstLevel", 64'(level), 64'(0));
        checkOutput("midRstInReady", 64'(in_ready), 64'(1));
        checkOutput("midRstBusy", 64'(busy), 64'(0));
        rstn = 1'b1;
        base = byteCount;
        repeat (10) cycle();
        checkOutput("noResidual", 64'(byteCount - base), 64'(0));

        // Randomized traffic: first heavy backpressure, then mixed
        for (int c = 0; c < 400; c++) begin
            applyStimulus(1'($urandom_range(0, 1)), WORD_W'($urandom), 1'($urandom_range(0, 1)),
                          (c < 200) ? ($urandom_range(0, 4) == 0) : 1'($urandom_range(0, 1)));
            cycle();
        end
        applyStimulus(1'b0, '0, 1'b0, 1'b1);
        waitN = 0;
        while (busy && waitN < 400) begin
            cycle();
            waitN++;
        end
        checkOutput("randDrainBusy", 64'(busy), 64'(0));
        checkOutput("randModelEmpty", 64'(modelQ.size()), 64'(0));

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
